// File: rtl/oc_vector_driver.sv
// Stimulus driver that walks {a,b,c} through all 8 combinations and captures the {y1,y0} response of each.
// Define OC_VEC_FLOAT_EN to release the bus (high-Z) for FLOAT_CYCLES between consecutive vectors.
module oc_vector_driver #(
  parameter int HOLD_CYCLES  = 4,
  parameter int FLOAT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        y0,
  input  logic        y1,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        busy,
  output logic        done,
  output logic [2:0]  vec_idx,
  output logic [15:0] results,
  output logic        results_valid
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
`ifdef OC_VEC_FLOAT_EN
    S_FLOAT,
`endif
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               hold_last;
  logic               drive_en;
  logic [2:0]         drive_val;

  assign hold_last = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

`ifdef OC_VEC_FLOAT_EN
  localparam int FLOAT_W = (FLOAT_CYCLES > 1) ? $clog2(FLOAT_CYCLES) : 1;

  logic [FLOAT_W-1:0] float_cnt;
  logic               float_last;

  assign float_last = (float_cnt == FLOAT_W'(FLOAT_CYCLES - 1));
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_DRIVE;
      S_DRIVE: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (hold_last) begin
          if (vec_idx == 3'd7) state_next = S_DONE;
`ifdef OC_VEC_FLOAT_EN
          else                 state_next = S_FLOAT;
`else
          else                 state_next = S_DRIVE;
`endif
        end
      end
`ifdef OC_VEC_FLOAT_EN
      S_FLOAT: begin
        if (abort)           state_next = S_IDLE;
        else if (float_last) state_next = S_DRIVE;
      end
`endif
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    drive_en  = 1'b1;
    drive_val = 3'd0;
    unique case (state)
      S_DRIVE: begin
        busy      = 1'b1;
        drive_val = vec_idx;
      end
`ifdef OC_VEC_FLOAT_EN
      S_FLOAT: begin
        busy     = 1'b1;
        drive_en = 1'b0;
      end
`endif
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign a = drive_en ? drive_val[2] : 1'bz;
  assign b = drive_en ? drive_val[1] : 1'bz;
  assign c = drive_en ? drive_val[0] : 1'bz;

  // vec_idx advances at the capture edge, so during FLOAT it already names the next vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_idx       <= 3'd0;
      hold_cnt      <= '0;
      results       <= 16'h0000;
      results_valid <= 1'b0;
`ifdef OC_VEC_FLOAT_EN
      float_cnt     <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            vec_idx       <= 3'd0;
            hold_cnt      <= '0;
            results       <= 16'h0000;
            results_valid <= 1'b0;
`ifdef OC_VEC_FLOAT_EN
            float_cnt     <= '0;
`endif
          end
        end
        S_DRIVE: begin
          if (abort) begin
            vec_idx  <= 3'd0;
            hold_cnt <= '0;
          end else if (hold_last) begin
            results[{vec_idx, 1'b0} +: 2] <= {y1, y0};
            hold_cnt <= '0;
            if (vec_idx == 3'd7) results_valid <= 1'b1;
            else                 vec_idx       <= vec_idx + 3'd1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
`ifdef OC_VEC_FLOAT_EN
        S_FLOAT: begin
          if (abort) begin
            vec_idx   <= 3'd0;
            float_cnt <= '0;
          end else if (float_last) begin
            float_cnt <= '0;
          end else begin
            float_cnt <= float_cnt + FLOAT_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oc_vector_driver.sv
// Directed bench for oc_vector_driver: reset, loopback and stuck-high sweeps, abort, and start-while-busy.
// Expectations follow OC_VEC_FLOAT_EN the same way the design does, using the default parameters.
module tb_oc_vector_driver;

  localparam int H = 4;
`ifdef OC_VEC_FLOAT_EN
  localparam int F   = 2;
  localparam int LAT = 46;
`else
  localparam int F   = 0;
  localparam int LAT = 32;
`endif
  localparam int P = H + F;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        stuck;
  wire         a;
  wire         b;
  wire         c;
  wire         y0;
  wire         y1;
  logic        busy;
  logic        done;
  logic [2:0]  vec_idx;
  logic [15:0] results;
  logic        results_valid;

  int total = 0;
  int bad   = 0;

  oc_vector_driver dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .y0            (y0),
    .y1            (y1),
    .a             (a),
    .b             (b),
    .c             (c),
    .busy          (busy),
    .done          (done),
    .vec_idx       (vec_idx),
    .results       (results),
    .results_valid (results_valid)
  );

  // Downstream model: loopback y0=c, y1=a with pull-ups, or both stuck high.
  assign y0 = stuck ? 1'b1 : ((c === 1'b0) ? 1'b0 : 1'b1);
  assign y1 = stuck ? 1'b1 : ((a === 1'b0) ? 1'b0 : 1'b1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full sweep from IDLE and checks every cycle against a cycle-count model.
  task automatic sweep(input string tag, input logic [15:0] exp_res, input bit poke);
    int n;
    bit poked;
    logic [2:0] k;
    logic [6:0] exp_bus;
    n = 0;
    poked = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_cleared"}, {15'd0, results_valid, results}, 32'd0);
    while (done !== 1'b1 && n < 200) begin
      k = 3'(n / P);
      if ((n % P) < H) exp_bus = {1'b1, k, k};
      else             exp_bus = {1'b1, k + 3'd1, 3'bzzz};
      check({tag, "_bus"}, {25'd0, busy, vec_idx, a, b, c}, {25'd0, exp_bus});
      if (poke && !poked && vec_idx == 3'd5) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, n, LAT);
    check({tag, "_done_cycle"}, {busy, a, b, c, results_valid, results},
          {1'b0, 3'b000, 1'b1, exp_res});
    tick();
    check({tag, "_idle_after"}, {done, busy, a, b, c, results_valid, results},
          {1'b0, 1'b0, 3'b000, 1'b1, exp_res});
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    stuck = 1'b0;
    tick();
    check("reset_state", {done, busy, vec_idx, a, b, c, results_valid, results},
          {1'b0, 1'b0, 3'd0, 3'b000, 1'b0, 16'h0000});
    rst = 1'b0;
    tick();

    // Partial stuck-high sweep, then asynchronous reset mid-cycle.
    stuck = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2 * P + 1) tick();
    check("pre_reset_results", {16'd0, results}, 32'h000F);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", {done, busy, a, b, c, results_valid, results},
          {1'b0, 1'b0, 3'b000, 1'b0, 16'h0000});
    tick();
    rst = 1'b0;
    tick();

    stuck = 1'b0;
    sweep("loopback", 16'hEE44, 1'b0);
    sweep("start_busy", 16'hEE44, 1'b1);
    stuck = 1'b1;
    sweep("stuck_high", 16'hFFFF, 1'b0);

    // Abort at vec_idx 3: vectors 0..2 stay captured, nothing else.
    stuck = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && vec_idx != 3'd3; i++) tick();
    check("abort_reach_idx3", {29'd0, vec_idx}, 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {busy, done, vec_idx, a, b, c, results_valid},
          {1'b0, 1'b0, 3'd0, 3'b000, 1'b0});
    for (int i = 0; i < LAT; i++) begin
      if (done !== 1'b0) check("abort_no_done", {31'd0, done}, 32'd0);
      tick();
    end
    check("abort_results", {15'd0, results_valid, results}, {15'd0, 1'b0, 16'h0004});

    // Abort alone in IDLE does nothing; start with abort in IDLE starts.
    abort = 1'b1;
    tick();
    check("abort_in_idle", {30'd0, busy, results_valid}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_wins", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_drive", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oc_vector_driver.md
Name: oc_vector_driver

Overview:
- Upstream stimulus stage for the open-collector three-input logic block.
- Sequences a,b,c through all 8 input combinations and holds each for a programmable number of cycles.
- Optionally releases the bus (high-Z) between vectors, exercising the pull-up float case.
- Captures the downstream y1,y0 response for every vector into a 16-bit result word and signals completion with a done pulse.

Parameters:
- HOLD_CYCLES, 4, cycles each vector is driven; legal range >=1.
- FLOAT_CYCLES, 2, cycles of high-Z between consecutive vectors; legal range >=1; used only with OC_VEC_FLOAT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; sampled in IDLE only.
- abort  in  1  synchronous cancel of a running sweep.
- y0  in  1  downstream output 0, pulled up externally.
- y1  in  1  downstream output 1, pulled up externally.
- a  out  1  stimulus bit 2; tri-state capable.
- b  out  1  stimulus bit 1; tri-state capable.
- c  out  1  stimulus bit 0; tri-state capable.
- busy  out  1  high while in DRIVE or FLOAT.
- done  out  1  one-cycle pulse when a sweep completes.
- vec_idx  out  3  index of the vector currently driven or pending.
- results  out  16  captured responses; {y1,y0} of vector k at bits [2k+1:2k].
- results_valid  out  1  results holds a complete sweep.

Behaviour:
- Reset, applied asynchronously: state=IDLE; a=b=c=0 (driven); busy=0; done=0; vec_idx=0; results=16'h0000; results_valid=0; hold and float counters=0.
- States: IDLE, DRIVE, FLOAT, DONE.
- IDLE:
  - a,b,c driven 0.
  - start=1 at an edge -> DRIVE. At the same edge: vec_idx=0, counters=0, results=0, results_valid=0.
- DRIVE:
  - {a,b,c}=vec_idx, driven.
  - Hold counter increments each cycle.
  - At the edge ending cycle HOLD_CYCLES-1: results[2*vec_idx+:2] <= {y1,y0}.
  - Exit on that edge: vec_idx==7 -> DONE. Otherwise -> FLOAT if enabled, else DRIVE with vec_idx+1 and hold counter=0.
- FLOAT:
  - a,b,c = 1'bz.
  - Lasts FLOAT_CYCLES cycles, then -> DRIVE with vec_idx+1 and hold counter=0.
  - vec_idx shows the next vector throughout FLOAT.
- DONE:
  - Lasts exactly one cycle. done=1, results_valid set, a,b,c driven 0.
  - -> IDLE. results and results_valid are held until the next start.
- busy=1 only in DRIVE and FLOAT.
- Latency from start edge to done-high cycle:
  - 8*HOLD_CYCLES cycles, plus 7*FLOAT_CYCLES when float is enabled.
  - Defaults: 46 cycles with float, 32 without.
- start while busy or in DONE: ignored.
- abort=1 in DRIVE or FLOAT -> IDLE at that edge. vec_idx=0, done stays 0, results_valid stays 0, partial results are retained.
- abort in IDLE or DONE: no effect.
- start and abort high together in IDLE: start wins.
- Reset mid-sweep: immediate return to reset values, including a,b,c driven 0 (never left floating).
- y0/y1 are sampled only at the capture edge; no synchronizer.
- The downstream block is combinational on the same clock domain.

Optional Feature:
- Macro OC_VEC_FLOAT_EN.
- Defined: the FLOAT state exists and a,b,c go high-Z for FLOAT_CYCLES between each pair of vectors. No float follows vector 7.
- Undefined: no FLOAT state, a,b,c are always driven, vectors are back-to-back, and FLOAT_CYCLES is unused.

Test Plan:
- Reset check: assert rst mid-cycle -> a=b=c=0, busy=0, done=0, results=16'h0000, results_valid=0 immediately (asynchronously).
- Loopback sweep: loopback y0=c, y1=a, float enabled, defaults -> done 46 cycles after start edge, results=16'hEE44, results_valid=1.
- Float observation: same loopback with OC_VEC_FLOAT_EN defined -> a,b,c read z for 2 cycles after each of vectors 0..6 and are never z after vector 7 or in IDLE. Macro undefined -> never z, done at 32 cycles, results=16'hEE44.
- Stuck-high response: y0=y1=1 constant -> results=16'hFFFF.
- Abort: abort asserted while vec_idx=3 -> IDLE next edge, no done pulse, results_valid=0. Bits [5:0] hold captured values and bits [15:6] are 0.
- Start while busy: start re-asserted at vec_idx=5 -> ignored, sweep completes normally. A second start after done -> results cleared to 0 and results_valid=0 at that edge.
